// File: rtl/qdec_pkg.sv
// Shared types for the quadrature decoder: phase encoding, direction constants
// and the forward-step predicate used by the decoder.
package qdec_pkg;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // True when moving prev -> nxt is one step along 00->01->11->10->00.
    function automatic logic ph_fwd(input phase_t prev, input phase_t nxt);
        logic r;
        r = 1'b0;
        case (prev)
            PH_00:   r = (nxt == PH_01);
            PH_01:   r = (nxt == PH_11);
            PH_11:   r = (nxt == PH_10);
            PH_10:   r = (nxt == PH_00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// One quadrature channel: 2-flop synchronizer followed by a glitch filter that
// accepts a new level only after FILT consecutive mismatching cycles.
module qdec_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILT < 2) ? 1 : $clog2(FILT + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILT - 1)) begin
                filt_d = sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder with filtered inputs, modulo-2^N position counter, clear/load.
// Illegal-transition (double-change) detection is compiled in with QDEC_ERR_EN.
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int N    = 8,
    parameter int FILT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] data_in,
    output logic         step,
    output logic         dir,
    output logic [N-1:0] pos,
    output logic         err,
    output logic         zero
);

    // Cycles after reset release before a level present at release reaches the filter output.
    localparam int SW = $clog2(FILT + 3);

    logic          a_filt, b_filt;
    phase_t        cur;
    phase_t        phase_q, phase_d;
    logic          seeded_q, seeded_d;
    logic [SW-1:0] st_cnt_q, st_cnt_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic [N-1:0]  pos_q, pos_d;
    logic          err_q, err_d;
    logic          fwd, rev;

    qdec_filter #(.FILT(FILT)) u_filt_a (.clk(clk), .rst_n(rst_n), .din(a_in), .dout(a_filt));
    qdec_filter #(.FILT(FILT)) u_filt_b (.clk(clk), .rst_n(rst_n), .din(b_in), .dout(b_filt));

    always_comb begin
        cur      = phase_t'({a_filt, b_filt});
        phase_d  = cur;
        seeded_d = seeded_q;
        st_cnt_d = st_cnt_q;
        if (!seeded_q) begin
            if (st_cnt_q == SW'(FILT + 2)) seeded_d = 1'b1;
            else                           st_cnt_d = st_cnt_q + SW'(1);
        end

        fwd = seeded_q && ph_fwd(phase_q, cur);
        rev = seeded_q && ph_fwd(cur, phase_q);

        step_d = fwd | rev;
        dir_d  = dir_q;
        if (fwd)      dir_d = DIR_UP;
        else if (rev) dir_d = DIR_DN;

        pos_d = pos_q;
        if (clr)       pos_d = '0;
        else if (load) pos_d = data_in;
        else if (fwd)  pos_d = pos_q + N'(1);
        else if (rev)  pos_d = pos_q - N'(1);

`ifdef QDEC_ERR_EN
        err_d = err_q;
        if (clr)                                                err_d = 1'b0;
        else if (seeded_q && ((phase_q ^ cur) == 2'b11))        err_d = 1'b1;
`else
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_00;
            seeded_q <= 1'b0;
            st_cnt_q <= '0;
            step_q   <= 1'b0;
            dir_q    <= DIR_UP;
            pos_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            seeded_q <= seeded_d;
            st_cnt_q <= st_cnt_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            err_q    <= err_d;
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign pos  = pos_q;
    assign err  = err_q;
    assign zero = (pos_q == '0);

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (N=8, FILT=3).
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_in, b_in, clr, load;
    logic [7:0] data_in;
    logic       step, dir, err, zero;
    logic [7:0] pos;

    int errors = 0;
    int checks = 0;
    int step_cnt = 0;
    int base;
    logic step_prev = 1'b0;
    logic dbl = 1'b0;

`ifdef QDEC_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    quad_decoder #(.N(8), .FILT(3)) dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in),
        .clr(clr), .load(load), .data_in(data_in),
        .step(step), .dir(dir), .pos(pos), .err(err), .zero(zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step) step_cnt++;
        if (step && step_prev) dbl = 1'b1;
        step_prev = step;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b);
        a_in = a;
        b_in = b;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; data_in = 8'h00;
        drive(1'b1, 1'b1);
        tick(3);
        check("rst_pos", pos, 0);
        check("rst_step", step, 0);
        check("rst_dir", dir, 1);
        check("rst_err", err, 0);
        check("rst_zero", zero, 1);

        // A=B=1 through reset: seed only
        rst_n = 1'b1;
        tick(20);
        check("seed_steps", step_cnt, 0);
        check("seed_err", err, 0);
        check("seed_pos", pos, 0);
        check("seed_zero", zero, 1);

        // 11 -> 10 -> 00 forward, then clear
        drive(1'b1, 1'b0); tick(8);
        drive(1'b0, 1'b0); tick(8);
        check("pre_pos", pos, 2);
        clr = 1'b1; tick(1); clr = 1'b0;
        check("clr_pos", pos, 0);
        tick(2);

        // full forward cycle with latency check on the first step
        base = step_cnt;
        drive(1'b0, 1'b1);
        tick(5);
        check("lat_e4_step", step, 0);
        tick(1);
        check("lat_e5_step", step, 1);
        check("lat_e5_pos", pos, 1);
        tick(1);
        check("lat_e6_step", step, 0);
        tick(1);
        drive(1'b1, 1'b1); tick(8);
        drive(1'b1, 1'b0); tick(8);
        drive(1'b0, 1'b0); tick(8);
        check("fwd_steps", step_cnt - base, 4);
        check("fwd_dir", dir, 1);
        check("fwd_pos", pos, 4);
        check("fwd_single", dbl, 0);

        // reverse from zero wraps to 255
        clr = 1'b1; tick(1); clr = 1'b0;
        base = step_cnt;
        drive(1'b1, 1'b0); tick(8);
        check("rev_steps", step_cnt - base, 1);
        check("rev_dir", dir, 0);
        check("rev_pos", pos, 255);
        check("rev_zero", zero, 0);
        drive(1'b0, 1'b0); tick(8);
        check("back_pos", pos, 0);
        check("back_dir", dir, 1);

        // 2-cycle glitch on A is rejected
        base = step_cnt;
        a_in = 1'b1; tick(2); a_in = 1'b0; tick(8);
        check("glitch_steps", step_cnt - base, 0);
        check("glitch_pos", pos, 0);

        // illegal double change 00 -> 11
        base = step_cnt;
        pos_preload();
        drive(1'b1, 1'b1); tick(8);
        check("ill_steps", step_cnt - base, 0);
        check("ill_pos", pos, 8'h05);
        check("ill_dir", dir, 1);
        check("ill_err", err, ERR_EXP);
        tick(5);
        check("ill_err_sticky", err, ERR_EXP);
        clr = 1'b1; tick(1); clr = 1'b0;
        check("ill_clr_err", err, 0);
        check("ill_clr_pos", pos, 0);
        tick(2);

        // load coincident with forward step 11 -> 10
        drive(1'b1, 1'b0);
        tick(5);
        load = 1'b1; data_in = 8'h80;
        tick(1);
        load = 1'b0;
        check("ld_pos", pos, 8'h80);
        check("ld_step", step, 1);
        check("ld_dir", dir, 1);
        tick(1);
        check("ld_after_step", step, 0);
        check("ld_after_pos", pos, 8'h80);
        tick(3);

        // 255 + 1 wraps to 0 (10 -> 00 forward)
        load = 1'b1; data_in = 8'hFF; tick(1); load = 1'b0;
        check("wrap_ld", pos, 8'hFF);
        drive(1'b0, 1'b0); tick(8);
        check("wrap_pos", pos, 0);
        check("wrap_zero", zero, 1);

        // reset mid-transition discards partial filter state
        base = step_cnt;
        drive(1'b0, 1'b1); tick(3);
        rst_n = 1'b0; tick(1);
        check("mid_rst_pos", pos, 0);
        rst_n = 1'b1; tick(12);
        check("mid_rst_steps", step_cnt - base, 0);
        check("mid_rst_pos2", pos, 0);
        check("mid_rst_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Puts a nonzero value in pos so "unchanged" is distinguishable from cleared.
    task automatic pos_preload();
        load = 1'b1; data_in = 8'h05; tick(1); load = 1'b0;
    endtask

endmodule
